// File: rtl/mmio_uart_periph.sv
// mmio_uart_periph
//   Memory-mapped peripheral page block for the RV32 SoC wrappers: hardware
//   UART (8N1, runtime divisor, TX/RX FIFOs), LED register and the legacy
//   bit-bang pages (RXRAW/TXRAW) so old firmware keeps working.
//
// Ports
//   clk      clock
//   rstn     synchronous active-low reset
//   sel      mapped-IO select (core addr[28])
//   wren     store strobe, qualified by sel
//   ren      load strobe, qualified by sel (only used for the RXDATA pop)
//   page     register page (core addr[15:12])
//   wdata    store data
//   rdata    registered read data, valid the cycle after the request
//   leds     LED register
//   uart_rx  asynchronous serial input
//   uart_tx  serial output
module mmio_uart_periph #(
  parameter int CLOCK_RATE = 12_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int LED_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sel,
  input  logic             wren,
  input  logic             ren,
  input  logic [3:0]       page,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] leds,
  input  logic             uart_rx,
  output logic             uart_tx
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(CLOCK_RATE / BAUD_RATE);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic             wr_en;
  logic             tx_push_req, led_wr, raw_wr, div_wr, stat_wr;
  logic [DIV_W-1:0] div_wval;

  // FIFOs
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop;

  // Control / status registers
  logic [DIV_W-1:0] div_reg;
  logic             tx_raw;
  logic             rx_ovr, frame_err, tx_drop;
  logic             tx_busy;
  logic [31:0]      status;

  // Shifters
  state_t           tx_state, rx_state;
  logic [DIV_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_idx, rx_idx;
  logic [7:0]       tx_shift, rx_shift;
  logic             txd;
  logic             tx_bit_end, rx_bit_end, rx_stop_sample;
  logic             rx_meta, rx_sync, rx_prev;

  // Upper store-data bits are don't-care for most pages.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign wr_en       = wren & sel;
  assign tx_push_req = wr_en && (page == 4'h0);
  assign led_wr      = wr_en && (page == 4'h1);
  assign raw_wr      = wr_en && (page == 4'h3);
  assign div_wr      = wr_en && (page == 4'h4);
  assign stat_wr     = wr_en && (page == 4'h5);
  assign div_wval    = (wdata[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : wdata[DIV_W-1:0];

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                    (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                    (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);

  assign tx_bit_end     = (tx_cnt == DIV_ONE);
  assign rx_bit_end     = (rx_cnt == DIV_ONE);
  assign rx_stop_sample = (rx_state == S_STOP) && rx_bit_end;

  // A full FIFO rejects a push even when a pop happens in the same cycle.
  assign tx_push = tx_push_req && !tx_full;
  // The shifter takes a byte when idle, or at the end of a stop bit so that
  // queued frames follow each other with no idle gap.
  assign tx_pop  = !tx_empty &&
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));
  assign rx_push = rx_stop_sample && rx_sync && !rx_full;
  assign rx_pop  = ren && sel && (page == 4'h6) && !rx_empty;

  assign tx_busy = !tx_empty || (tx_state != S_IDLE);
  assign status  = {26'b0, tx_drop, frame_err, rx_ovr, !rx_empty, tx_busy, tx_full};

  // FIFO storage, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
  end

  // FIFO pointers, control registers and sticky flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      leds      <= '0;
      tx_raw    <= 1'b1;
      div_reg   <= DIV_RESET;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_drop   <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (led_wr)  leds      <= wdata[LED_W-1:0];
      if (raw_wr)  tx_raw    <= wdata[0];
      if (div_wr)  div_reg   <= div_wval;
      // Write-1-to-clear; a set event in the same cycle wins.
      rx_ovr    <= (rx_stop_sample && rx_sync && rx_full) |
                   (rx_ovr & ~(stat_wr & wdata[3]));
      frame_err <= (rx_stop_sample && !rx_sync) |
                   (frame_err & ~(stat_wr & wdata[4]));
      tx_drop   <= (tx_push_req && tx_full) |
                   (tx_drop & ~(stat_wr & wdata[5]));
    end
  end

  // TX shifter. uart_tx is registered, so the line lags txd by one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= tx_raw & txd;
      case (tx_state)
        S_IDLE: begin
          txd <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd_ptr[AW-1:0]];
            tx_cnt   <= div_reg;
            txd      <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= 3'd0;
            tx_cnt   <= div_reg;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - DIV_ONE;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= div_reg;
            if (tx_idx == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_ONE;
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rd_ptr[AW-1:0]];
              tx_cnt   <= div_reg;
              txd      <= 1'b0;
              tx_state <= S_START;
            end else begin
              txd      <= 1'b1;
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - DIV_ONE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // RX synchroniser and shifter. The start bit is checked half a bit in,
  // then every sample lands a whole bit later, i.e. near mid-bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= div_reg >> 1;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_bit_end) begin
            if (rx_sync) begin
              rx_state <= S_IDLE;
            end else begin
              rx_cnt   <= div_reg;
              rx_idx   <= 3'd0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - DIV_ONE;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= div_reg;
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - DIV_ONE;
          end
        end
        S_STOP: begin
          // Push / frame error is decided combinationally from rx_stop_sample.
          if (rx_bit_end) rx_state <= S_IDLE;
          else            rx_cnt   <= rx_cnt - DIV_ONE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Read data follows page every cycle, independent of the strobes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else begin
      case (page)
        4'h1:    rdata <= 32'(leds);
        4'h2:    rdata <= {31'b0, rx_sync};
        4'h3:    rdata <= {31'b0, tx_raw};
        4'h4:    rdata <= 32'(div_reg);
        4'h5:    rdata <= status;
        // An empty FIFO reports a zero byte rather than a stale entry.
        4'h6:    rdata <= {rx_empty, 23'b0,
                           rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[AW-1:0]]};
        default: rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_periph.sv
module tb_mmio_uart_periph;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic        wren = 1'b0;
  logic        ren = 1'b0;
  logic [3:0]  page = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  leds;
  logic        uart_rx;
  logic        uart_tx;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0]  bytes [0:31];
  logic [7:0]  rx_q [$];
  logic [31:0] r, v, e;
  logic [7:0]  b;
  logic        rbits [0:23];
  int          d, k;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  mmio_uart_periph #(
    .CLOCK_RATE(12_000_000),
    .BAUD_RATE (115200),
    .LED_W     (8),
    .FIFO_DEPTH(16),
    .DIV_W     (16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sel    (sel),
    .wren   (wren),
    .ren    (ren),
    .page   (page),
    .wdata  (wdata),
    .rdata  (rdata),
    .leds   (leds),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] p, input logic [31:0] dat);
    sel = 1'b1; wren = 1'b1; page = p; wdata = dat;
    @(posedge clk); #1;
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] p, input logic pop, output logic [31:0] dat);
    sel = 1'b1; ren = pop; page = p;
    @(posedge clk); #1;
    dat = rdata;
    sel = 1'b0; ren = 1'b0;
  endtask

  // Expected line level i cycles after the first TXDATA write edge: the line
  // falls two edges after the write, and n frames of 10*d cycles follow
  // back-to-back (start 0, data LSB first, stop 1).
  function automatic logic exp_tx(input int i, input int n, input int dv);
    int t, f, bit_no;
    t = i - 2;
    if (t < 0 || t >= 10 * dv * n) return 1'b1;
    f = t / (10 * dv);
    bit_no = (t % (10 * dv)) / dv;
    if (bit_no == 0) return 1'b0;
    if (bit_no == 9) return 1'b1;
    return bytes[f][bit_no-1];
  endfunction

  // Writes bytes[0..n-1] on consecutive cycles and follows the line and the
  // STATUS busy bit cycle by cycle.
  task automatic tx_frames(input int n, input int dv);
    int total;
    bus_write(4'h4, 32'(dv));
    for (int j = 0; j < n; j++) begin
      sel = 1'b1; wren = 1'b1; page = 4'h0;
      wdata = {24'($urandom), bytes[j]};
      @(posedge clk); #1;
      check("tx_line", {31'b0, uart_tx}, {31'b0, exp_tx(j, n, dv)});
    end
    sel = 1'b0; wren = 1'b0; page = 4'h5;
    total = 10 * dv * n;
    for (int i = n; i <= total + 4; i++) begin
      @(posedge clk); #1;
      check("tx_line", {31'b0, uart_tx}, {31'b0, exp_tx(i, n, dv)});
      if (i <= total)          check("tx_busy", {31'b0, rdata[1]}, 32'h1);
      else if (i >= total + 3) check("tx_idle", {31'b0, rdata[1]}, 32'h0);
    end
  endtask

  task automatic send_rx(input logic [7:0] dat, input logic stop_bit, input int dv);
    rx_drv = 1'b0;
    wait_cycles(dv);
    for (int i = 0; i < 8; i++) begin
      rx_drv = dat[i];
      wait_cycles(dv);
    end
    rx_drv = stop_bit;
    wait_cycles(dv);
    rx_drv = 1'b1;
    wait_cycles(dv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected $finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_leds", {24'b0, leds}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    bus_read(4'h5, 1'b0, r); check("rst_status", r, 32'h0);
    bus_read(4'h4, 1'b0, r); check("rst_div", r, 32'd104);

    // LED register, only LED_W bits kept
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'h1A5 : $urandom;
      bus_write(4'h1, v);
      check("led_port", {24'b0, leds}, v & 32'hFF);
      bus_read(4'h1, 1'b0, r); check("led_read", r, v & 32'hFF);
    end

    // Unlisted page: reads 0, writes ignored
    e = {24'b0, leds};
    bus_write(4'h7, $urandom);
    bus_read(4'h7, 1'b0, r); check("page7_read", r, 32'h0);
    check("page7_no_led", {24'b0, leds}, e);

    // Divisor: clamped to a minimum of 2, DIV_W bits wide
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: v = 32'h0;
        1: v = 32'h1;
        2: v = 32'h0001_0001;
        3: v = 32'h3;
        default: v = $urandom;
      endcase
      e = ((v & 32'hFFFF) < 2) ? 32'h2 : (v & 32'hFFFF);
      bus_write(4'h4, v);
      bus_read(4'h4, 1'b0, r); check("div_read", r, e);
    end

    // TX: 0x55 at DIV=4, then random single and back-to-back frames
    bytes[0] = 8'h55;
    tx_frames(1, 4);
    bytes[0] = 8'($urandom);
    tx_frames(1, int'($urandom_range(2, 6)));
    bytes[0] = 8'($urandom);
    bytes[1] = 8'($urandom);
    tx_frames(2, int'($urandom_range(2, 5)));

    // TX overflow, with the line looped back into RX: 17 writes accepted,
    // the 18th dropped; RX keeps the first 16 and flags overrun.
    loopback = 1'b1;
    bus_write(4'h4, 32'd4);
    for (int i = 0; i < 17; i++) begin
      bytes[i] = 8'($urandom);
      sel = 1'b1; wren = 1'b1; page = 4'h0; wdata = {24'b0, bytes[i]};
      @(posedge clk); #1;
    end
    wdata = 32'hEE;
    @(posedge clk); #1;
    sel = 1'b0; wren = 1'b0;
    bus_read(4'h5, 1'b0, r); check("txdrop_status", r, 32'h23);
    bus_write(4'h5, 32'h20);
    bus_read(4'h5, 1'b0, r); check("txdrop_clear", r, 32'h03);
    k = 0;
    r = 32'h2;
    while (r[1] && k < 2000) begin
      bus_read(4'h5, 1'b0, r);
      k++;
    end
    check("tx_drain_busy", {31'b0, r[1]}, 32'h0);
    wait_cycles(20);
    loopback = 1'b0;
    bus_read(4'h5, 1'b0, r); check("rxovr_status", r, 32'h0C);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h6, 1'b1, r); check("loop_rxdata", r, {24'b0, bytes[i]});
    end
    bus_read(4'h6, 1'b1, r); check("loop_rx_empty", r, 32'h8000_0000);
    bus_write(4'h5, 32'h08);
    bus_read(4'h5, 1'b0, r); check("rxovr_clear", r, 32'h0);

    // RX: 0xA3 at DIV=8
    bus_write(4'h4, 32'd8);
    send_rx(8'hA3, 1'b1, 8);
    bus_read(4'h5, 1'b0, r); check("rx_status", r, 32'h04);
    bus_read(4'h6, 1'b1, r); check("rx_a3", r, 32'h0000_00A3);
    bus_read(4'h6, 1'b1, r); check("rx_empty", r, 32'h8000_0000);
    bus_read(4'h5, 1'b0, r); check("rx_status_empty", r, 32'h0);

    // RX: random bytes at a random divisor, read back in order
    d = int'($urandom_range(6, 12));
    bus_write(4'h4, 32'(d));
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_q.push_back(b);
      send_rx(b, 1'b1, d);
    end
    bus_read(4'h5, 1'b0, r); check("rx_rand_status", r, 32'h04);
    while (rx_q.size() > 0) begin
      b = rx_q.pop_front();
      bus_read(4'h6, 1'b1, r); check("rx_rand_data", r, {24'b0, b});
    end
    bus_read(4'h6, 1'b1, r); check("rx_rand_empty", r, 32'h8000_0000);

    // RX: short glitch is a false start
    bus_write(4'h4, 32'd8);
    rx_drv = 1'b0;
    wait_cycles(3);
    rx_drv = 1'b1;
    wait_cycles(30);
    bus_read(4'h5, 1'b0, r); check("rx_glitch", r, 32'h0);

    // RX: low stop bit -> framing error, no byte
    send_rx(8'($urandom), 1'b0, 8);
    bus_read(4'h5, 1'b0, r); check("frameerr_status", r, 32'h10);
    bus_write(4'h5, 32'h10);
    bus_read(4'h5, 1'b0, r); check("frameerr_clear", r, 32'h0);

    // Reset in mid-frame
    bus_write(4'h4, 32'd4);
    bus_write(4'h0, 32'h00);
    wait_cycles(10);
    check("midframe_low", {31'b0, uart_tx}, 32'h0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midrst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("midrst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    bus_read(4'h5, 1'b0, r); check("midrst_status", r, 32'h0);
    bus_read(4'h4, 1'b0, r); check("midrst_div", r, 32'd104);
    check("midrst_uart_idle", {31'b0, uart_tx}, 32'h1);

    // Bit-bang compatibility: TXRAW forces the line, RXRAW follows uart_rx
    bus_write(4'h3, 32'h0);
    wait_cycles(1);
    check("txraw_low", {31'b0, uart_tx}, 32'h0);
    bus_read(4'h3, 1'b0, r); check("txraw_read0", r, 32'h0);
    bus_write(4'h3, 32'h1);
    wait_cycles(1);
    check("txraw_high", {31'b0, uart_tx}, 32'h1);
    bus_read(4'h3, 1'b0, r); check("txraw_read1", r, 32'h1);
    page = 4'h2;
    for (int i = 0; i < 24; i++) begin
      rbits[i] = 1'($urandom);
      rx_drv = rbits[i];
      @(posedge clk); #1;
      // Two synchroniser stages, the read register is the second edge's output.
      if (i >= 2) check("rxraw", rdata, {31'b0, rbits[i-2]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_uart_periph.md
# mmio_uart_periph

Parametrised memory-mapped peripheral block for the RV32 SoC wrappers. It replaces the hand-built LED/bit-bang UART decode in the board top level with a hardware UART (8N1, runtime-programmable divisor, TX/RX FIFOs) and a width-parametrised LED port. It keeps the existing page map (addr[15:12]), so old bit-bang firmware still runs. It sits on the core data bus behind the addr[28] mapped-IO select and supplies the registered read data that the top level muxes into the core.

## Interface
- CLOCK_RATE, 12_000_000, clk frequency in Hz
- BAUD_RATE, 115200, reset value of divisor = CLOCK_RATE/BAUD_RATE
- LED_W, 8, LED port width (1..32)
- FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, >=2)
- DIV_W, 16, divisor register width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- sel  in  1  mapped-IO access (addr[28] of the core address)
- wren  in  1  store strobe; effective only with sel
- ren  in  1  load strobe; effective only with sel (read side effects only)
- page  in  4  register page, addr[15:12]
- wdata  in  32  store data
- rdata  out  32  registered read data, valid the cycle after the request
- leds  out  LED_W  LED register
- uart_rx  in  1  asynchronous serial input
- uart_tx  out  1  serial output

## Operation
- Register pages. Writes use wren&sel. rdata is updated every cycle from page regardless of strobes. Unlisted pages read 0 and ignore writes.
  - 0x0 TXDATA: write pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and TXDROP is set. Reads 0.
  - 0x1 LED: read/write, leds <= wdata[LED_W-1:0].
  - 0x2 RXRAW: reads {31'b0, rx_sync}.
  - 0x3 TXRAW: write tx_raw <= wdata[0]. Reads {31'b0, tx_raw}.
  - 0x4 DIV: read/write, in clk cycles per bit. Writes below 2 store 2. Reads are zero-extended.
  - 0x5 STATUS: bit0 TX full, bit1 TX busy (FIFO non-empty or shifter active), bit2 RX non-empty, bit3 RXOVR, bit4 FRAMEERR, bit5 TXDROP. Writing 1 to bits 3..5 clears the corresponding sticky bits. A set event in the same cycle wins over a clear.
  - 0x6 RXDATA: read returns {~rx_nonempty, 23'b0, head[7:0]}. ren&sel&page==6 while non-empty pops the FIFO in the request cycle.
- uart_tx = tx_raw & txd, where txd is the shifter output and is 1 when idle.
- rx_sync: a 2-FF synchroniser on uart_rx. Its reset value is 1.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop one byte and go to START.
  - Each bit lasts DIV cycles; the bit counter is reloaded from DIV at every bit start.
  - Data is sent LSB first, 8 bits, then one stop bit (1) lasting DIV cycles.
  - STOP returns to IDLE, or goes straight to START if the FIFO is non-empty (no idle gap).
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a 1->0 transition of rx_sync goes to START.
  - START: sample at DIV/2 (floor). If the sample is high, it is a false start; return to IDLE.
  - DATA: sample every DIV cycles, 8 bits LSB first.
  - STOP: sample after DIV cycles. High: push the byte (if the FIFO is full, drop it and set RXOVR). Low: discard the byte and set FRAMEERR. Then go to IDLE.
- FIFOs use a single clock with pointers one bit wider than log2(FIFO_DEPTH) and wrap modulo depth.
  - A push when full is rejected even if a pop occurs in the same cycle.
  - A push and pop on a non-full, non-empty FIFO in the same cycle keep the count unchanged.
- A DIV write in mid-frame takes effect at the next bit boundary of each FSM.

## Timing
- Reset values:
  - rdata=0, leds=0, tx_raw=1, uart_tx=1.
  - DIV=CLOCK_RATE/BAUD_RATE truncated to DIV_W.
  - FIFOs empty, FSMs IDLE, sticky bits 0, rx_sync=1.
- Reset mid-frame aborts immediately: uart_tx is 1 on the first cycle after the reset edge, and FIFO contents are lost.
- Read latency: 1 cycle. rdata at edge N+1 reflects the page and state present in cycle N. An RXDATA pop is visible in STATUS on the following read.
- TXDATA write at edge N into an empty FIFO with TX idle: the byte is in the FIFO at N; uart_tx falls at edge N+2.
- Frame length: exactly 10*DIV cycles. Back-to-back frames have no gap.
- RX push: 2 sync cycles + 9.5*DIV cycles after the falling edge on uart_rx (±1 cycle).

## Test plan
- Reset: hold rstn=0 for 2 cycles. Then uart_tx=1, leds=0, STATUS reads 0x00, DIV reads 104 (12 MHz / 115200).
- TX: DIV=4, write 0x55 to page 0. uart_tx = 0,1,0,1,0,1,0,1,0,1, each level lasting 4 cycles, falling at write edge +2. STATUS bit1 clears after 40 cycles.
- TX overflow: DIV=4, 17 back-to-back writes with depth 16. The shifter pops the first, so all are accepted. A further write beyond a full FIFO sets STATUS=0x23 (full, busy, TXDROP). Writing 0x20 to STATUS clears TXDROP.
- RX loopback: drive 0xA3 8N1 at DIV=8 on uart_rx. STATUS bit2=1. A page-6 read with ren returns 0x000000A3, and the next read returns 0x80000000.
- RX errors: a 3-cycle low glitch at DIV=8 produces no byte. A frame with a low stop bit sets FRAMEERR (STATUS 0x10) and pushes no byte. 17 frames without reads set RXOVR and keep the first 16 bytes.
- Compat: write 0 to page 3 forces uart_tx=0 while idle. Page 2 tracks uart_rx with a 2-cycle delay. Page 1 write of 0x1A5 with LED_W=8 gives leds=0xA5.
